// File: rtl/ads131a0x_timer_pkg.sv
// Shared register map, control bit positions and limits for the multi-channel timer.
package ads131a0x_timer_pkg;

    localparam int MAX_CH = 8;

    localparam logic [1:0] STATUS  = 2'd0;
    localparam logic [1:0] CONTROL = 2'd1;
    localparam logic [1:0] PERIOD  = 2'd2;
    localparam logic [1:0] SNAP    = 2'd3;

    localparam int CTRL_IE_BIT    = 0;
    localparam int CTRL_CONT_BIT  = 1;
    localparam int CTRL_START_BIT = 2;
    localparam int CTRL_STOP_BIT  = 3;
    localparam int CTRL_PSC_LSB   = 8;
    localparam int CTRL_PSC_W     = 8;

    function automatic logic [31:0] ctrl_word(input logic ie, input logic cont,
                                              input logic [CTRL_PSC_W-1:0] psc);
        logic [31:0] w;
        w = 32'd0;
        w[CTRL_IE_BIT] = ie;
        w[CTRL_CONT_BIT] = cont;
        w[CTRL_PSC_LSB +: CTRL_PSC_W] = psc;
        return w;
    endfunction

endpackage

// File: rtl/ads131a0x_timer_ch.sv
// One independent down-counting timer channel with status/control/period/snapshot registers.
// Optional tick prescaler in control[15:8] is built when TIMER_PRESCALER_EN is defined.
module ads131a0x_timer_ch
    import ads131a0x_timer_pkg::*;
#(
    parameter int          CNT_W        = 32,
    parameter logic [31:0] RESET_PERIOD = 32'h017D783F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [1:0]  reg_sel,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [CNT_W-1:0] RST_VAL = RESET_PERIOD[CNT_W-1:0];

    logic [CNT_W-1:0] counter_q, counter_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] snap_q, snap_d;
    logic             running_q, running_d;
    logic             to_q, to_d;
    logic             ie_q, ie_d;
    logic             cont_q, cont_d;
    logic             reload_q, reload_d;
    logic             fired_q, fired_d;

    logic wr_status_s, wr_ctrl_s, wr_period_s, wr_snap_s;
    logic start_s, stop_s, zero_s, hit_s, evt_s, tick_s;
    logic [CTRL_PSC_W-1:0] psc_field_s;

    // Register-write decode and zero/timeout detection
    always_comb begin
        wr_status_s = wr_en && (reg_sel == STATUS);
        wr_ctrl_s   = wr_en && (reg_sel == CONTROL);
        wr_period_s = wr_en && (reg_sel == PERIOD);
        wr_snap_s   = wr_en && (reg_sel == SNAP);
        start_s     = wr_ctrl_s && wdata[CTRL_START_BIT];
        stop_s      = wr_ctrl_s && wdata[CTRL_STOP_BIT];
        zero_s      = (counter_q == '0);
        hit_s       = running_q && tick_s && zero_s;
        // fired_q suppresses repeat flags while a zero period pins the counter at 0
        evt_s       = hit_s && !fired_q;
    end

`ifdef TIMER_PRESCALER_EN
    logic [CTRL_PSC_W-1:0] presc_q, presc_d;
    logic [CTRL_PSC_W-1:0] psc_cnt_q, psc_cnt_d;

    assign tick_s      = (psc_cnt_q == presc_q);
    assign psc_field_s = presc_q;

    // Prescaler divisor and cycle count; the count restarts on start or period write
    always_comb begin
        if (wr_ctrl_s) begin
            presc_d = wdata[CTRL_PSC_LSB +: CTRL_PSC_W];
        end else begin
            presc_d = presc_q;
        end
        if (start_s || wr_period_s) begin
            psc_cnt_d = '0;
        end else if (running_q) begin
            psc_cnt_d = tick_s ? '0 : psc_cnt_q + 8'd1;
        end else begin
            psc_cnt_d = psc_cnt_q;
        end
    end

    // Prescaler state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q   <= '0;
            psc_cnt_q <= '0;
        end else begin
            presc_q   <= presc_d;
            psc_cnt_q <= psc_cnt_d;
        end
    end
`else
    assign tick_s      = 1'b1;
    assign psc_field_s = '0;
`endif

    // Next-state logic for counter, period, flags and configuration
    always_comb begin
        counter_d = counter_q;
        period_d  = period_q;
        snap_d    = snap_q;
        running_d = running_q;
        to_d      = to_q;
        ie_d      = ie_q;
        cont_d    = cont_q;
        reload_d  = wr_period_s;
        fired_d   = fired_q;

        if (reload_q) begin
            counter_d = period_q;
        end else if (running_q && tick_s) begin
            counter_d = zero_s ? period_q : counter_q - CNT_W'(1);
        end else begin
            counter_d = counter_q;
        end

        if (hit_s && !cont_q) begin
            running_d = 1'b0;
        end else begin
            running_d = running_q;
        end
        if (start_s) begin
            running_d = 1'b1;
        end else if (stop_s || wr_period_s) begin
            running_d = 1'b0;
        end else begin
            running_d = running_d;
        end

        if (start_s || wr_period_s) begin
            fired_d = 1'b0;
        end else if (hit_s) begin
            fired_d = 1'b1;
        end else if (!zero_s) begin
            fired_d = 1'b0;
        end else begin
            fired_d = fired_q;
        end

        // A status write in the same cycle as a timeout leaves the flag clear
        if (wr_status_s) begin
            to_d = 1'b0;
        end else if (evt_s) begin
            to_d = 1'b1;
        end else begin
            to_d = to_q;
        end

        if (wr_ctrl_s) begin
            ie_d   = wdata[CTRL_IE_BIT];
            cont_d = wdata[CTRL_CONT_BIT];
        end else begin
            ie_d   = ie_q;
            cont_d = cont_q;
        end

        if (wr_period_s) begin
            period_d = wdata[CNT_W-1:0];
        end else begin
            period_d = period_q;
        end

        if (wr_snap_s) begin
            snap_d = counter_q;
        end else begin
            snap_d = snap_q;
        end
    end

    // Channel state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter_q <= RST_VAL;
            period_q  <= RST_VAL;
            snap_q    <= '0;
            running_q <= 1'b0;
            to_q      <= 1'b0;
            ie_q      <= 1'b0;
            cont_q    <= 1'b0;
            reload_q  <= 1'b0;
            fired_q   <= 1'b0;
        end else begin
            counter_q <= counter_d;
            period_q  <= period_d;
            snap_q    <= snap_d;
            running_q <= running_d;
            to_q      <= to_d;
            ie_q      <= ie_d;
            cont_q    <= cont_d;
            reload_q  <= reload_d;
            fired_q   <= fired_d;
        end
    end

    // Register read view for the top-level mux
    always_comb begin
        rdata = 32'd0;
        case (reg_sel)
            STATUS:  rdata = {30'd0, running_q, to_q};
            CONTROL: rdata = ctrl_word(ie_q, cont_q, psc_field_s);
            PERIOD:  rdata[CNT_W-1:0] = period_q;
            SNAP:    rdata[CNT_W-1:0] = snap_q;
            default: rdata = 32'd0;
        endcase
    end

    assign irq = to_q & ie_q;

endmodule

// File: rtl/ads131a0x_timer_mc.sv
// Avalon-MM multi-channel timer: address decode, registered read mux and interrupt OR.
// Per-channel prescaler is included when TIMER_PRESCALER_EN is defined.
module ads131a0x_timer_mc
    import ads131a0x_timer_pkg::*;
#(
    parameter int          NUM_CH       = 4,
    parameter int          CNT_W        = 32,
    parameter logic [31:0] RESET_PERIOD = 32'h017D783F,
    parameter int          AW           = $clog2(NUM_CH) + 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [AW-1:0]     address,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output logic [NUM_CH-1:0] irq_vec
);

    localparam int CH_W = (AW > 2) ? AW - 2 : 1;

    logic [CH_W-1:0]   ch_s;
    logic [1:0]        reg_s;
    logic              wr_s;
    logic [NUM_CH-1:0] ch_wr_s;
    logic [31:0]       ch_rd_s [NUM_CH];
    logic [31:0]       readdata_q, readdata_d;

    if (AW > 2) begin : g_ch_idx
        assign ch_s = address[AW-1:2];
    end else begin : g_ch_zero
        assign ch_s = '0;
    end

    assign reg_s = address[1:0];
    assign wr_s  = chipselect && !write_n;

    // Channel select; indices with no channel behind them read 0 and drop writes
    always_comb begin
        ch_wr_s    = '0;
        readdata_d = 32'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (32'(ch_s) == i) begin
                ch_wr_s[i] = wr_s;
                readdata_d = ch_rd_s[i];
            end else begin
                ch_wr_s[i] = 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ads131a0x_timer_ch #(
            .CNT_W        (CNT_W),
            .RESET_PERIOD (RESET_PERIOD)
        ) u_ch (
            .clk     (clk),
            .rst     (reset),
            .wr_en   (ch_wr_s[i]),
            .reg_sel (reg_s),
            .wdata   (writedata),
            .rdata   (ch_rd_s[i]),
            .irq     (irq_vec[i])
        );
    end

    // Read data register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata_q <= 32'd0;
        end else begin
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |irq_vec;

endmodule

// File: tb/tb_ads131a0x_timer_mc.sv
// Self-checking bench for ads131a0x_timer_mc: directed register scenarios plus a
// randomized run checked against an arithmetic timeout-schedule model.
module tb_ads131a0x_timer_mc;
    import ads131a0x_timer_pkg::*;

    localparam int          NUM_CH = 3;
    localparam int          CNT_W  = 16;
    localparam int          AW     = $clog2(NUM_CH) + 2;
    localparam logic [31:0] RST_P  = 32'h017D783F;
    localparam logic [31:0] RST_TR = RST_P & 32'h0000FFFF;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              chipselect = 1'b0;
    logic              write_n = 1'b1;
    logic [AW-1:0]     address = '0;
    logic [31:0]       writedata = 32'd0;
    logic [31:0]       readdata;
    logic              irq;
    logic [NUM_CH-1:0] irq_vec;

    ads131a0x_timer_mc #(
        .NUM_CH       (NUM_CH),
        .CNT_W        (CNT_W),
        .RESET_PERIOD (RST_P),
        .AW           (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write_n    (write_n),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .irq_vec    (irq_vec)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus tasks start and end on a falling edge; the access happens at the rising edge between.
    task automatic bus_wr(input int ch, input logic [1:0] r, input logic [31:0] d);
        address    = AW'(ch * 4 + int'(r));
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_rd(input int ch, input logic [1:0] r, output logic [31:0] d);
        address    = AW'(ch * 4 + int'(r));
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(negedge clk);
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference schedule: a channel started at edge s with period p times out at
    // s + k*(p+1), k >= 1 (only k = 1 when one-shot or p == 0); a status write at
    // edge c erases every timeout at or before c.
    int s_st[NUM_CH];
    int per[NUM_CH];
    int lclr[NUM_CH];
    bit cnt_en[NUM_CH];
    bit act[NUM_CH];

    function automatic bit exp_to(input int c, input int t);
        int first;
        int last_e;
        if (!act[c]) return 1'b0;
        first = s_st[c] + per[c] + 1;
        if (t < first) return 1'b0;
        if (!cnt_en[c] || per[c] == 0) last_e = first;
        else last_e = s_st[c] + ((t - s_st[c]) / (per[c] + 1)) * (per[c] + 1);
        return last_e > lclr[c];
    endfunction

    logic [31:0] rd;
    bit any_exp;

    initial begin
        // Reset state
        #1 reset = 1'b1;
        #1;
        check_eq("rst_readdata", readdata, 32'd0);
        check_eq("rst_irq", 32'(irq), 32'd0);
        check_eq("rst_irq_vec", 32'(irq_vec), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus_rd(0, PERIOD, rd);  check_eq("rst_period", rd, RST_TR);
        bus_rd(0, STATUS, rd);  check_eq("rst_status", rd, 32'd0);
        bus_rd(0, CONTROL, rd); check_eq("rst_control", rd, 32'd0);
        bus_rd(0, SNAP, rd);    check_eq("rst_snap", rd, 32'd0);
        bus_wr(0, SNAP, 32'd0);
        bus_rd(0, SNAP, rd);    check_eq("rst_counter", rd, RST_TR);

        // Continuous ch1, period 5: flag every 6 cycles
        bus_wr(1, PERIOD, 32'd5);
        bus_wr(1, CONTROL, 32'h7);
        for (int k = 1; k <= 6; k++) begin
            step(1);
            check_eq($sformatf("cont_irqvec1_k%0d", k), 32'(irq_vec[1]), 32'(k == 6));
        end
        check_eq("cont_irq", 32'(irq), 32'd1);
        bus_wr(1, STATUS, 32'd0);
        check_eq("cont_clr_k7", 32'(irq_vec[1]), 32'd0);
        for (int k = 8; k <= 12; k++) begin
            step(1);
            check_eq($sformatf("cont_irqvec1_k%0d", k), 32'(irq_vec[1]), 32'(k == 12));
        end
        bus_wr(1, CONTROL, 32'h8);
        bus_wr(1, STATUS, 32'd0);

        // One-shot ch0, period 3
        bus_wr(0, PERIOD, 32'd3);
        bus_wr(0, CONTROL, 32'h5);
        for (int k = 1; k <= 10; k++) begin
            step(1);
            check_eq($sformatf("oneshot_irqvec0_k%0d", k), 32'(irq_vec[0]), 32'(k >= 4));
        end
        bus_rd(0, STATUS, rd); check_eq("oneshot_status", rd, 32'h1);
        bus_wr(0, STATUS, 32'd0);
        check_eq("oneshot_irq_drop", 32'(irq), 32'd0);

        // Start+stop together: start wins
        bus_wr(2, CONTROL, 32'hC);
        bus_rd(2, STATUS, rd); check_eq("startstop_status", rd, 32'h2);
        bus_wr(2, CONTROL, 32'h8);

        // Status clear on the same edge as the timeout
        bus_wr(0, PERIOD, 32'd3);
        bus_wr(0, CONTROL, 32'h5);
        step(3);
        bus_wr(0, STATUS, 32'd0);
        check_eq("clrwin_irqvec0", 32'(irq_vec[0]), 32'd0);
        step(3);
        check_eq("clrwin_irqvec0_later", 32'(irq_vec[0]), 32'd0);
        bus_rd(0, STATUS, rd); check_eq("clrwin_status", rd, 32'd0);

        // Snapshot while running, then period write while running
        bus_wr(2, PERIOD, 32'd100);
        bus_wr(2, CONTROL, 32'h4);
        step(9);
        bus_wr(2, SNAP, 32'd0);
        bus_rd(2, SNAP, rd);   check_eq("snap_running", rd, 32'd91);
        bus_wr(2, PERIOD, 32'd40);
        bus_rd(2, STATUS, rd); check_eq("perwr_status", rd, 32'd0);
        bus_wr(2, SNAP, 32'd0);
        bus_rd(2, SNAP, rd);   check_eq("perwr_counter", rd, 32'd40);
        step(5);
        bus_wr(2, SNAP, 32'd0);
        bus_rd(2, SNAP, rd);   check_eq("perwr_held", rd, 32'd40);

        // Channel index beyond NUM_CH
        bus_wr(NUM_CH, PERIOD, 32'h55);
        for (int r = 0; r < 4; r++) begin
            bus_rd(NUM_CH, 2'(r), rd);
            check_eq($sformatf("badch_reg%0d", r), rd, 32'd0);
        end
        bus_rd(0, PERIOD, rd); check_eq("badch_nowrite", rd, 32'd3);

`ifdef TIMER_PRESCALER_EN
        bus_wr(0, PERIOD, 32'd2);
        bus_wr(0, CONTROL, 32'h0305);
        for (int k = 1; k <= 13; k++) begin
            step(1);
            check_eq($sformatf("psc_irqvec0_k%0d", k), 32'(irq_vec[0]), 32'(k >= 12));
        end
        bus_rd(0, CONTROL, rd); check_eq("psc_control", rd, 32'h0301);
        bus_wr(0, CONTROL, 32'h8);
        bus_wr(0, STATUS, 32'd0);
`else
        bus_wr(0, CONTROL, 32'h0301);
        bus_rd(0, CONTROL, rd); check_eq("nopsc_control", rd, 32'h0001);
        bus_wr(0, CONTROL, 32'h0);
`endif

        // Randomized schedules on all channels, random status clears
        for (int round = 0; round < 3; round++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                bus_wr(c, CONTROL, 32'h8);
                bus_wr(c, STATUS, 32'd0);
                act[c] = 1'b0;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                per[c]    = int'($urandom_range(0, 9));
                cnt_en[c] = 1'($urandom_range(0, 1));
                bus_wr(c, PERIOD, 32'(per[c]));
                bus_wr(c, CONTROL, 32'h5 | (32'(cnt_en[c]) << 1));
                s_st[c] = cyc;
                lclr[c] = cyc;
                act[c]  = 1'b1;
            end
            for (int n = 0; n < 60; n++) begin
                if ($urandom_range(0, 2) == 0) begin
                    int rc;
                    rc = int'($urandom_range(0, NUM_CH - 1));
                    bus_wr(rc, STATUS, 32'd0);
                    lclr[rc] = cyc;
                end else begin
                    step(1);
                end
                any_exp = 1'b0;
                for (int c = 0; c < NUM_CH; c++) begin
                    check_eq($sformatf("rnd%0d_irqvec%0d_t%0d", round, c, cyc),
                             32'(irq_vec[c]), 32'(exp_to(c, cyc)));
                    any_exp = any_exp | exp_to(c, cyc);
                end
                check_eq($sformatf("rnd%0d_irq_t%0d", round, cyc), 32'(irq), 32'(any_exp));
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            bus_wr(c, CONTROL, 32'h8);
            bus_wr(c, STATUS, 32'd0);
        end

        // Asynchronous reset in the middle of a count
        bus_wr(1, PERIOD, 32'd5);
        bus_wr(1, CONTROL, 32'h7);
        step(5);
        bus_rd(1, PERIOD, rd);
        check_eq("arst_pre_irq", 32'(irq), 32'd1);
        check_eq("arst_pre_readdata", readdata, 32'd5);
        #2 reset = 1'b1;
        #1;
        check_eq("arst_readdata", readdata, 32'd0);
        check_eq("arst_irq", 32'(irq), 32'd0);
        check_eq("arst_irq_vec", 32'(irq_vec), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            step(1);
            check_eq($sformatf("arst_post_irq_k%0d", k), 32'(irq), 32'd0);
        end
        bus_rd(1, STATUS, rd);  check_eq("arst_status", rd, 32'd0);
        bus_rd(1, CONTROL, rd); check_eq("arst_control", rd, 32'd0);
        bus_rd(1, PERIOD, rd);  check_eq("arst_period", rd, RST_TR);
        bus_rd(1, SNAP, rd);    check_eq("arst_snap", rd, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
